// File: rtl/accel_buffer_mc.sv
// Multi-channel AXI-Stream ingress buffer: N_CH independent FIFOs merged onto one
// output stream with packet-atomic round-robin arbitration and a source-channel tag.
module accel_buffer_mc #(
    parameter  int N_CH         = 4,
    parameter  int BUFF_DEPTH   = 16,
    parameter  int BUFF_WORD    = 32,
    parameter  int PROG_FULL_N  = 5,
    parameter  int PROG_EMPTY_N = 5,
    localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LW           = $clog2(BUFF_DEPTH) + 1
) (
    input  logic                      accel_clk,
    input  logic                      rst_n,
    input  logic [N_CH*BUFF_WORD-1:0] s_tdata,
    input  logic [N_CH-1:0]           s_tvalid,
    input  logic [N_CH-1:0]           s_tlast,
    output logic [N_CH-1:0]           s_tready,
    output logic [BUFF_WORD-1:0]      m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    output logic [CH_W-1:0]           m_tdest,
    input  logic                      m_tready,
    input  logic [N_CH-1:0]           flush,
    output logic [N_CH*LW-1:0]        level,
    output logic [N_CH-1:0]           prog_full,
    output logic [N_CH-1:0]           prog_empty
);

    localparam int AW = $clog2(BUFF_DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(BUFF_DEPTH);
    localparam logic [LW-1:0] PF_TH    = LW'(BUFF_DEPTH - PROG_FULL_N);
    localparam logic [LW-1:0] PE_TH    = LW'(PROG_EMPTY_N);

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    logic [BUFF_WORD:0] r_mem   [N_CH][BUFF_DEPTH];
    logic [AW-1:0]      r_wptr  [N_CH];
    logic [AW-1:0]      r_rptr  [N_CH];
    logic [LW-1:0]      r_level [N_CH];
    state_t             r_state;
    logic [CH_W-1:0]    r_grant;
    logic [CH_W-1:0]    r_rr_ptr;

    logic [N_CH-1:0]    w_wr;
    logic [N_CH-1:0]    w_rd;
    logic [N_CH-1:0]    w_req;
    logic               w_pop;
    logic [CH_W-1:0]    w_arb_idx;
    logic [CH_W-1:0]    w_rr_next;
    logic [BUFF_WORD:0] w_head;

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        s_tready   = '0;
        w_wr       = '0;
        w_rd       = '0;
        w_req      = '0;
        level      = '0;
        prog_full  = '0;
        prog_empty = '0;
        for (int i = 0; i < N_CH; i++) begin
            s_tready[i]         = rst_n && (r_level[i] != FULL_LVL) && !flush[i];
            w_wr[i]             = s_tvalid[i] && s_tready[i];
            w_rd[i]             = w_pop && (r_grant == CH_W'(i)) && !flush[i];
            w_req[i]            = (r_level[i] != '0) && !flush[i];
            level[i*LW +: LW]   = r_level[i];
            prog_full[i]        = r_level[i] >= PF_TH;
            prog_empty[i]       = r_level[i] <= PE_TH;
        end
    end

    // Descending scan so the closest requester at or above rr_ptr is the last one written.
    always_comb begin
        w_arb_idx = r_rr_ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_req[(int'(r_rr_ptr) + k) % N_CH])
                w_arb_idx = CH_W'((int'(r_rr_ptr) + k) % N_CH);
        end
    end

    assign w_rr_next = (r_grant == CH_W'(N_CH - 1)) ? '0 : r_grant + 1'b1;
    assign w_head    = r_mem[r_grant][r_rptr[r_grant]];
    assign m_tvalid  = (r_state == ST_LOCK) && (r_level[r_grant] != '0);
    assign m_tdata   = w_head[BUFF_WORD-1:0];
    assign m_tlast   = m_tvalid && w_head[BUFF_WORD];
    assign m_tdest   = r_grant;
    assign w_pop     = m_tvalid && m_tready;

    // NOTE: the storage array has no reset; level and pointers alone decide which entries are live.
    always_ff @(posedge accel_clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (w_wr[i])
                r_mem[i][r_wptr[i]] <= {s_tlast[i], s_tdata[i*BUFF_WORD +: BUFF_WORD]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every channel sees pre-edge values.
    always_ff @(posedge accel_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (flush[i]) begin
                    r_wptr[i]  <= '0;
                    r_rptr[i]  <= '0;
                    r_level[i] <= '0;
                end else begin
                    if (w_wr[i])
                        r_wptr[i] <= r_wptr[i] + 1'b1;
                    if (w_rd[i])
                        r_rptr[i] <= r_rptr[i] + 1'b1;
                    if (w_wr[i] && !w_rd[i])
                        r_level[i] <= r_level[i] + 1'b1;
                    else if (!w_wr[i] && w_rd[i])
                        r_level[i] <= r_level[i] - 1'b1;
                end
            end
        end
    end

    // A flush of the granted channel wins over a simultaneous tlast handshake.
    always_ff @(posedge accel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_arb_idx;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (flush[r_grant]) begin
                        r_state <= ST_IDLE;
                    end else if (w_pop && m_tlast) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
